// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder behind the MEM-stage request/stall port.
// Optional LASTACC_BYPASS_EN: last-access buffer completes matching reads in IDLE.
module dmem_responder #(
  parameter int ADDR_W  = 13,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  input  logic        halt,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic [15:0]       wdat_q;
  logic              wr_q;
  logic [15:0]       data_q;
  logic              err_q;

  logic [15:0] mem_q [2**ADDR_W];

  logic              idle, busy;
  logic              req, bad, hit;
  logic              accept, commit;
  logic [ADDR_W-1:0] idx_in;
  logic [15:0]       rdata;
  logic              unused_addr;

  assign unused_addr = ^addr;

  assign idle   = (state_q == IDLE);
  assign busy   = (state_q == BUSY);
  assign idx_in = addr[ADDR_W:1];

  // the err cycle ignores requests so err and stall never coincide
  assign req    = (rd | wr) & ~halt & ~err_q;
  assign bad    = req & ((rd & wr) | addr[0]);
  assign accept = idle & req & ~bad & ~hit;
  assign commit = busy & (cnt_q == 4'd0);
  assign rdata  = mem_q[idx_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      idle: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      busy: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= 16'h0;
      wr_q    <= 1'b0;
      data_q  <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= idle & bad;
      if (accept) begin
        idx_q  <= idx_in;
        wdat_q <= data_in;
        wr_q   <= wr;
      end
      if (commit) data_q <= wr_q ? 16'h0 : rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_q) mem_q[idx_q] <= wdat_q;
  end

`ifdef LASTACC_BYPASS_EN
  logic              bvld_q;
  logic [ADDR_W-1:0] bidx_q;
  logic [15:0]       bdat_q;

  assign hit = idle & req & rd & ~wr & ~addr[0]
             & bvld_q & (bidx_q == idx_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bvld_q <= 1'b0;
      bidx_q <= '0;
      bdat_q <= 16'h0;
    end else if (commit) begin
      bvld_q <= 1'b1;
      bidx_q <= idx_q;
      bdat_q <= wr_q ? wdat_q : rdata;
    end
  end

  assign data_out = hit ? bdat_q : data_q;
`else
  assign hit      = 1'b0;
  assign data_out = data_q;
`endif

  assign stall = accept | busy;
  assign done  = (state_q == DONE) | hit;
  assign err   = err_q;

endmodule
